// File: rtl/dmro_link_trainer_if.sv
// Control/status bundle between the DMRO link trainer and its environment
// (transmitter config, receive deserializer and supervisory logic).
interface dmro_link_trainer_if;
  logic        Start;
  logic        Retrain;
  logic [31:0] WordIn;
  logic [4:0]  AlignOffset;
  logic        TestMode;
  logic        Locked;
  logic        Fail;
  logic        Busy;
  logic [5:0]  Attempts;

  modport master (
    output Start, Retrain, WordIn,
    input  AlignOffset, TestMode, Locked, Fail, Busy, Attempts
  );

  modport slave (
    input  Start, Retrain, WordIn,
    output AlignOffset, TestMode, Locked, Fail, Busy, Attempts
  );
endinterface

// File: rtl/dmro_link_trainer.sv
// DMRO link trainer: sweeps the deserializer bit offset until the received
// words continue a valid PRBS7 stream, then drops TestMode and reports lock.
module dmro_link_trainer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CHECK_WORDS   = 16,
  parameter int unsigned INIT_OFFSET   = 0
) (
  input logic                CLK,
  input logic                RSTn,
  dmro_link_trainer_if.slave link
);

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] CHECK_TARGET = 8'(CHECK_WORDS);
  localparam logic [4:0] OFFSET_RESET = 5'(INIT_OFFSET);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, LOCKED, FAIL} state_t;

  state_t      state_q, state_d;
  logic [4:0]  offset_q, offset_d;
  logic        testMode_q, testMode_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;
  logic [5:0]  attempts_q, attempts_d;
  logic [31:0] prev_q, prev_d;
  logic [7:0]  settleCnt_q, settleCnt_d;
  logic [7:0]  goodCnt_q, goodCnt_d;
  logic        prime_q, prime_d;
  logic [31:0] pred;

  // Extends the history window (bit 32 = latest received bit) by 32 new bits.
  function automatic logic [31:0] prbs7Next(input logic [31:0] hist);
    logic [63:0] s;
    s = {hist, 32'h0};
    for (int j = 31; j >= 0; j--) begin
      s[j] = s[j+6] ^ s[j+7];
    end
    return s[31:0];
  endfunction

  assign pred = prbs7Next(prev_q);

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    testMode_d  = testMode_q;
    locked_d    = locked_q;
    fail_d      = fail_q;
    attempts_d  = attempts_q;
    prev_d      = prev_q;
    settleCnt_d = settleCnt_q;
    goodCnt_d   = goodCnt_q;
    prime_d     = prime_q;

    case (state_q)
      IDLE: begin
        if (link.Start) begin
          state_d     = SETTLE;
          testMode_d  = 1'b1;
          attempts_d  = '0;
          settleCnt_d = '0;
        end
      end
      SETTLE: begin
        settleCnt_d = settleCnt_q + 8'd1;
        if (settleCnt_q == SETTLE_LAST) begin
          state_d   = CHECK;
          prime_d   = 1'b1;
          goodCnt_d = '0;
        end
      end
      CHECK: begin
        if (goodCnt_q == CHECK_TARGET) begin
          state_d    = LOCKED;
          testMode_d = 1'b0;
          locked_d   = 1'b1;
        end else if (prime_q) begin
          prev_d  = link.WordIn;
          prime_d = 1'b0;
        end else if ((link.WordIn == pred) && (link.WordIn != 32'h0)) begin
          goodCnt_d = goodCnt_q + 8'd1;
          prev_d    = link.WordIn;
        end else begin
          // All-zero words also land here: they obey the recurrence but carry no pattern.
          offset_d   = offset_q + 5'd1;
          attempts_d = attempts_q + 6'd1;
          if (attempts_q == 6'd31) begin
            state_d    = FAIL;
            fail_d     = 1'b1;
            testMode_d = 1'b0;
          end else begin
            state_d     = SETTLE;
            settleCnt_d = '0;
          end
        end
      end
      LOCKED, FAIL: begin
        if (link.Retrain) begin
          state_d     = SETTLE;
          testMode_d  = 1'b1;
          locked_d    = 1'b0;
          fail_d      = 1'b0;
          attempts_d  = '0;
          settleCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      offset_q    <= OFFSET_RESET;
      testMode_q  <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      attempts_q  <= '0;
      prev_q      <= '0;
      settleCnt_q <= '0;
      goodCnt_q   <= '0;
      prime_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      testMode_q  <= testMode_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      attempts_q  <= attempts_d;
      prev_q      <= prev_d;
      settleCnt_q <= settleCnt_d;
      goodCnt_q   <= goodCnt_d;
      prime_q     <= prime_d;
    end
  end

  assign link.AlignOffset = offset_q;
  assign link.TestMode    = testMode_q;
  assign link.Locked      = locked_q;
  assign link.Fail        = fail_q;
  assign link.Busy        = busy_q;
  assign link.Attempts    = attempts_q;

endmodule

// File: tb/tb_dmro_link_trainer.sv
// Bench for dmro_link_trainer: a serial PRBS7 source feeds the DUT only when
// its offset matches the true offset; misaligned offsets see random garbage.
module tb_dmro_link_trainer;
  localparam int SETTLE = 4;
  localparam int CHECKW = 16;
  localparam int INIT   = 0;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  dmro_link_trainer_if link();

  dmro_link_trainer #(
    .SETTLE_CYCLES(SETTLE),
    .CHECK_WORDS  (CHECKW),
    .INIT_OFFSET  (INIT)
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .link(link)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int trueOffset = 0;
  bit zeroMode = 1'b0;
  logic [6:0] hist = 7'h7F;
  logic [4:0] offQ[$];
  logic [5:0] attQ[$];
  logic e0TestMode, e0Busy, e0Locked, e0Fail;
  logic [5:0] e0Attempts;

  // Next 32 bits of the serial PRBS7 stream, earliest bit in word bit 31.
  function automatic logic [31:0] nextWord();
    logic [31:0] w;
    logic b;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      b = hist[5] ^ hist[6];
      hist = {hist[5:0], b};
      w[i] = b;
    end
    return w;
  endfunction

  // Cost of each rejected offset is settle + prime + one compare; lock needs settle,
  // prime, CHECKW good compares and the lock decision edge.
  function automatic int expectedEdges(input int rejects);
    return rejects * (SETTLE + 2) + SETTLE + 2 + CHECKW;
  endfunction

  initial begin
    link.WordIn = '0;
    forever begin
      @(negedge CLK);
      if (zeroMode) link.WordIn = '0;
      else if (int'(link.AlignOffset) == trueOffset) link.WordIn = nextWord();
      else link.WordIn = $urandom;
    end
  end

  task automatic doReset();
    @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic pulse(input bit useRetrain);
    @(negedge CLK);
    if (useRetrain) link.Retrain = 1'b1;
    else link.Start = 1'b1;
    @(posedge CLK);
    #1;
    e0TestMode = link.TestMode;
    e0Busy     = link.Busy;
    e0Locked   = link.Locked;
    e0Fail     = link.Fail;
    e0Attempts = link.Attempts;
    offQ.delete();
    attQ.delete();
    offQ.push_back(link.AlignOffset);
    attQ.push_back(link.Attempts);
    @(negedge CLK);
    link.Start   = 1'b0;
    link.Retrain = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int edges);
    edges = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge CLK);
      #1;
      if (link.AlignOffset != offQ[$]) offQ.push_back(link.AlignOffset);
      if (link.Attempts != attQ[$]) attQ.push_back(link.Attempts);
      if (link.Locked || link.Fail) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (link.AlignOffset !== 5'(INIT) || link.TestMode !== 1'b0 || link.Locked !== 1'b0 ||
        link.Fail !== 1'b0 || link.Busy !== 1'b0 || link.Attempts !== 6'd0)
      begin errors++; $display("[TB] FAIL reset_values got off=%0d tm=%b lk=%b fl=%b bz=%b att=%0d want off=%0d zeros",
        link.AlignOffset, link.TestMode, link.Locked, link.Fail, link.Busy, link.Attempts, INIT); end
    RSTn = 1'b1;
  endtask

  task automatic test_aligned();
    int edges;
    trueOffset = 0;
    pulse(1'b0);
    checks++;
    if (e0TestMode !== 1'b1 || e0Busy !== 1'b1 || e0Locked !== 1'b0)
      begin errors++; $display("[TB] FAIL start_e0 got tm=%b bz=%b lk=%b want 1 1 0", e0TestMode, e0Busy, e0Locked); end
    waitDone(200, edges);
    checks++;
    if (edges != expectedEdges(0))
      begin errors++; $display("[TB] FAIL aligned_latency got %0d want %0d", edges, expectedEdges(0)); end
    checks++;
    if (link.Locked !== 1'b1 || link.AlignOffset !== 5'd0 || link.Attempts !== 6'd0 ||
        link.TestMode !== 1'b0 || link.Busy !== 1'b0)
      begin errors++; $display("[TB] FAIL aligned_outputs got lk=%b off=%0d att=%0d tm=%b bz=%b want 1 0 0 0 0",
        link.Locked, link.AlignOffset, link.Attempts, link.TestMode, link.Busy); end
  endtask

  task automatic test_offset_search();
    int edges;
    bit ok;
    doReset();
    trueOffset = 5;
    pulse(1'b0);
    waitDone(400, edges);
    checks++;
    if (edges != expectedEdges(5))
      begin errors++; $display("[TB] FAIL search_latency got %0d want %0d", edges, expectedEdges(5)); end
    checks++;
    if (link.Locked !== 1'b1 || link.AlignOffset !== 5'd5 || link.Attempts !== 6'd5)
      begin errors++; $display("[TB] FAIL search_lock got lk=%b off=%0d att=%0d want 1 5 5",
        link.Locked, link.AlignOffset, link.Attempts); end
    ok = (offQ.size() == 6) && (attQ.size() == 6);
    for (int i = 0; i < 6 && ok; i++) ok = (offQ[i] == 5'(i)) && (attQ[i] == 6'(i));
    checks++;
    if (!ok)
      begin errors++; $display("[TB] FAIL search_steps got %0d offset steps %0d attempt steps want 0..5 each",
        offQ.size(), attQ.size()); end
  endtask

  task automatic test_retrain_ignored();
    int edges;
    bit held;
    trueOffset = 7;
    pulse(1'b1);
    waitDone(400, edges);
    checks++;
    if (edges != expectedEdges(2) || link.AlignOffset !== 5'd7 || link.Attempts !== 6'd2)
      begin errors++; $display("[TB] FAIL retrain_to7 got edges=%0d off=%0d att=%0d want %0d 7 2",
        edges, link.AlignOffset, link.Attempts, expectedEdges(2)); end
    pulse(1'b0);
    held = (e0Locked === 1'b1) && (e0TestMode === 1'b0) && (e0Busy === 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      if (link.Locked !== 1'b1 || link.Busy !== 1'b0 || link.AlignOffset !== 5'd7 || link.Attempts !== 6'd2) held = 1'b0;
    end
    checks++;
    if (!held)
      begin errors++; $display("[TB] FAIL start_in_locked got lk=%b bz=%b off=%0d att=%0d want 1 0 7 2",
        link.Locked, link.Busy, link.AlignOffset, link.Attempts); end
    pulse(1'b1);
    checks++;
    if (e0TestMode !== 1'b1 || e0Locked !== 1'b0 || e0Attempts !== 6'd0 || e0Busy !== 1'b1)
      begin errors++; $display("[TB] FAIL retrain_e0 got tm=%b lk=%b att=%0d bz=%b want 1 0 0 1",
        e0TestMode, e0Locked, e0Attempts, e0Busy); end
    waitDone(200, edges);
    checks++;
    if (edges != expectedEdges(0) || link.Locked !== 1'b1 || link.AlignOffset !== 5'd7)
      begin errors++; $display("[TB] FAIL relock7 got edges=%0d lk=%b off=%0d want %0d 1 7",
        edges, link.Locked, link.AlignOffset, expectedEdges(0)); end
  endtask

  task automatic test_wrap();
    int edges;
    bit ok;
    trueOffset = 30;
    pulse(1'b1);
    waitDone(1000, edges);
    checks++;
    if (edges != expectedEdges(23) || link.AlignOffset !== 5'd30 || link.Attempts !== 6'd23)
      begin errors++; $display("[TB] FAIL move_to30 got edges=%0d off=%0d att=%0d want %0d 30 23",
        edges, link.AlignOffset, link.Attempts, expectedEdges(23)); end
    trueOffset = 2;
    pulse(1'b1);
    waitDone(400, edges);
    checks++;
    if (edges != expectedEdges(4) || link.Locked !== 1'b1 || link.AlignOffset !== 5'd2 || link.Attempts !== 6'd4)
      begin errors++; $display("[TB] FAIL wrap_lock got edges=%0d lk=%b off=%0d att=%0d want %0d 1 2 4",
        edges, link.Locked, link.AlignOffset, link.Attempts, expectedEdges(4)); end
    ok = (offQ.size() == 5);
    for (int i = 0; i < 5 && ok; i++) ok = (int'(offQ[i]) == (30 + i) % 32);
    checks++;
    if (!ok)
      begin errors++; $display("[TB] FAIL wrap_sequence got %0d distinct offsets ending %0d want 30,31,0,1,2",
        offQ.size(), offQ[$]); end
  endtask

  task automatic test_no_pattern();
    int edges;
    doReset();
    zeroMode = 1'b1;
    pulse(1'b0);
    waitDone(1000, edges);
    checks++;
    if (edges != 32 * (SETTLE + 2))
      begin errors++; $display("[TB] FAIL fail_latency got %0d want %0d", edges, 32 * (SETTLE + 2)); end
    checks++;
    if (link.Fail !== 1'b1 || link.Locked !== 1'b0 || link.Attempts !== 6'd32 ||
        link.TestMode !== 1'b0 || link.AlignOffset !== 5'(INIT) || link.Busy !== 1'b0)
      begin errors++; $display("[TB] FAIL fail_outputs got fl=%b lk=%b att=%0d tm=%b off=%0d bz=%b want 1 0 32 0 %0d 0",
        link.Fail, link.Locked, link.Attempts, link.TestMode, link.AlignOffset, link.Busy, INIT); end
    repeat (8) @(posedge CLK);
    #1;
    checks++;
    if (link.Attempts !== 6'd32 || link.Fail !== 1'b1)
      begin errors++; $display("[TB] FAIL fail_hold got att=%0d fl=%b want 32 1", link.Attempts, link.Fail); end
    zeroMode = 1'b0;
    trueOffset = INIT;
    pulse(1'b1);
    checks++;
    if (e0Fail !== 1'b0 || e0TestMode !== 1'b1 || e0Attempts !== 6'd0)
      begin errors++; $display("[TB] FAIL fail_retrain_e0 got fl=%b tm=%b att=%0d want 0 1 0", e0Fail, e0TestMode, e0Attempts); end
    waitDone(200, edges);
    checks++;
    if (edges != expectedEdges(0) || link.Locked !== 1'b1 || link.Fail !== 1'b0)
      begin errors++; $display("[TB] FAIL fail_relock got edges=%0d lk=%b fl=%b want %0d 1 0",
        edges, link.Locked, link.Fail, expectedEdges(0)); end
  endtask

  task automatic test_reset_mid_check();
    int edges;
    bit quiet;
    doReset();
    trueOffset = 0;
    pulse(1'b0);
    waitDone(1 + SETTLE + 9, edges);
    checks++;
    if (edges != -1 || link.Busy !== 1'b1 || link.TestMode !== 1'b1)
      begin errors++; $display("[TB] FAIL mid_check_state got edges=%0d bz=%b tm=%b want -1 1 1", edges, link.Busy, link.TestMode); end
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (link.AlignOffset !== 5'(INIT) || link.TestMode !== 1'b0 || link.Locked !== 1'b0 ||
        link.Fail !== 1'b0 || link.Busy !== 1'b0 || link.Attempts !== 6'd0)
      begin errors++; $display("[TB] FAIL async_reset got off=%0d tm=%b lk=%b fl=%b bz=%b att=%0d want %0d zeros",
        link.AlignOffset, link.TestMode, link.Locked, link.Fail, link.Busy, link.Attempts, INIT); end
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (link.Busy !== 1'b0 || link.TestMode !== 1'b0 || link.Locked !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet)
      begin errors++; $display("[TB] FAIL idle_after_reset got bz=%b tm=%b lk=%b want 0 0 0", link.Busy, link.TestMode, link.Locked); end
    pulse(1'b0);
    waitDone(200, edges);
    checks++;
    if (edges != expectedEdges(0) || link.Locked !== 1'b1)
      begin errors++; $display("[TB] FAIL lock_after_reset got edges=%0d lk=%b want %0d 1", edges, link.Locked, expectedEdges(0)); end
  endtask

  initial begin
    link.Start   = 1'b0;
    link.Retrain = 1'b0;
    test_reset();
    test_aligned();
    test_offset_search();
    test_retrain_ignored();
    test_wrap();
    test_no_pattern();
    test_reset_mid_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
